// File: rtl/pu_riscv_wbarb_pkg.sv
// rtl/pu_riscv_wbarb_pkg.sv - shared types and constants for the register-file write-back arbiter
package pu_riscv_wbarb_pkg;

  // Requester slot assignment on the arbiter inputs
  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_MUL = 2;

  // Default widths; the top-level XLEN/AR_BITS parameters default to these
  localparam int WB_XLEN    = 64;
  localparam int WB_AR_BITS = 5;

  // One holding-buffer entry. is_null marks a write to x0 that still
  // consumes a grant slot but never reaches the register file.
  typedef struct packed {
    logic                  valid;
    logic                  is_null;
    logic [WB_AR_BITS-1:0] dst;
    logic [WB_XLEN-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/pu_riscv_rr_arbiter.sv
// rtl/pu_riscv_rr_arbiter.sv - N-way round-robin arbiter with internal priority pointer
module pu_riscv_rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next_ptr;
  logic          w_any;

  // Pick the first requester at or after the pointer, then wrap to index 0
  always_comb begin
    o_gnt      = '0;
    w_any      = 1'b0;
    w_next_ptr = r_ptr;
    for (int i = 0; i < N; i++) begin
      if (!w_any && (i >= int'(r_ptr)) && i_req[i]) begin
        w_any      = 1'b1;
        o_gnt[i]   = 1'b1;
        w_next_ptr = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!w_any && i_req[i]) begin
        w_any      = 1'b1;
        o_gnt[i]   = 1'b1;
        w_next_ptr = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  // Pointer moves just past the winner; it holds when nothing is granted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= w_next_ptr;
    end
  end

endmodule

// File: rtl/pu_riscv_rf_wbarb.sv
// rtl/pu_riscv_rf_wbarb.sv - register-file write-back arbiter with per-requester holding buffers
module pu_riscv_rf_wbarb
  import pu_riscv_wbarb_pkg::*;
#(
  parameter int XLEN    = WB_XLEN,
  parameter int AR_BITS = WB_AR_BITS,
  parameter int NREQ    = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ-1:0][AR_BITS-1:0]  req_dst,
  input  logic [NREQ-1:0][XLEN-1:0]     req_data,
  output logic [NREQ-1:0]               req_ready,
  output logic [AR_BITS-1:0]            rf_dst,
  output logic [XLEN-1:0]               rf_dstv,
  output logic                          rf_we,
  output logic [31:0]                   pend_mask,
  input  logic                          du_stall,
  output logic                          du_idle
);

  wb_entry_t       r_buf [NREQ];
  logic [NREQ-1:0] w_buf_valid;
  logic [NREQ-1:0] w_arb_req;
  logic [NREQ-1:0] w_gnt;
  logic [NREQ-1:0] w_accept;

  // Occupancy vector; a reset cycle withholds requests so buffered writes are dropped, not written
  always_comb begin
    w_buf_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_buf_valid[i] = r_buf[i].valid;
    end
    w_arb_req = w_buf_valid & {NREQ{~rst}};
  end

  pu_riscv_rr_arbiter #(
    .N (NREQ)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req (w_arb_req),
    .o_gnt (w_gnt)
  );

  // Acceptance: free (or draining) slot, no stall, and no other in-flight write to the same register
  always_comb begin
    logic [NREQ-1:0] rdy;
    logic [NREQ-1:0] acc;
    logic            conf;
    rdy  = '0;
    acc  = '0;
    conf = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      conf = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
        if ((j != i) && r_buf[j].valid && !w_gnt[j] && (r_buf[j].dst == req_dst[i])) begin
          conf = 1'b1;
        end
      end
      for (int k = 0; k < i; k++) begin
        if (acc[k] && (req_dst[k] == req_dst[i])) begin
          conf = 1'b1;
        end
      end
      rdy[i] = !rst && !du_stall && (!r_buf[i].valid || w_gnt[i]) && !conf;
      acc[i] = req_valid[i] && rdy[i];
    end
    req_ready = rdy;
    w_accept  = acc;
  end

  // Buffers load on acceptance, otherwise empty on grant; a reload in the grant cycle keeps them full
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_accept[i]) begin
          r_buf[i].valid   <= 1'b1;
          r_buf[i].is_null <= (req_dst[i] == '0);
          r_buf[i].dst     <= req_dst[i];
          r_buf[i].data    <= req_data[i];
        end else if (w_gnt[i]) begin
          r_buf[i].valid <= 1'b0;
        end
      end
    end
  end

  // Write port driven straight from the granted buffer; x0 entries burn the slot with rf_we low
  always_comb begin
    rf_we   = 1'b0;
    rf_dst  = '0;
    rf_dstv = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        rf_we   = !r_buf[i].is_null;
        rf_dst  = r_buf[i].dst;
        rf_dstv = r_buf[i].data;
      end
    end
  end

  // Pending-write mask for hazard detection plus debug drain status
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_buf[i].valid && !r_buf[i].is_null) begin
        pend_mask[r_buf[i].dst] = 1'b1;
      end
    end
    du_idle = du_stall && (w_buf_valid == '0);
  end

endmodule

// File: tb/tb_pu_riscv_rf_wbarb.sv
// tb/tb_pu_riscv_rf_wbarb.sv - self-checking bench for the write-back arbiter
module tb_pu_riscv_rf_wbarb;

  localparam int N = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req_valid;
  logic [N-1:0][4:0]   req_dst;
  logic [N-1:0][63:0]  req_data;
  logic [N-1:0]        req_ready;
  logic [4:0]          rf_dst;
  logic [63:0]         rf_dstv;
  logic                rf_we;
  logic [31:0]         pend_mask;
  logic                du_stall;
  logic                du_idle;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pu_riscv_rf_wbarb #(
    .XLEN    (64),
    .AR_BITS (5),
    .NREQ    (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_dst   (req_dst),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_dst    (rf_dst),
    .rf_dstv   (rf_dstv),
    .rf_we     (rf_we),
    .pend_mask (pend_mask),
    .du_stall  (du_stall),
    .du_idle   (du_idle)
  );

  // Reference model: slot contents, rotating priority start, and pending writes in acceptance order
  bit          m_v    [N];
  logic [4:0]  m_dst  [N];
  logic [63:0] m_data [N];
  int          m_ptr = 0;
  logic [68:0] sbq [$];

  int          e_gnt;
  logic [N-1:0] e_ready, e_acc;
  logic        e_we;
  logic [4:0]  e_dst;
  logic [63:0] e_data;
  logic [31:0] e_mask;
  logic        e_idle;

  task automatic model_eval();
    e_gnt = -1;
    if (!rst) begin
      for (int o = 0; o < N; o++) begin
        int idx;
        idx = (m_ptr + o) % N;
        if (e_gnt < 0 && m_v[idx]) e_gnt = idx;
      end
    end
    e_we   = (e_gnt >= 0) && (m_dst[e_gnt] != 5'd0);
    e_dst  = (e_gnt >= 0) ? m_dst[e_gnt] : 5'd0;
    e_data = (e_gnt >= 0) ? m_data[e_gnt] : 64'd0;
    e_acc  = '0;
    for (int i = 0; i < N; i++) begin
      bit ok;
      ok = !rst && !du_stall && (!m_v[i] || e_gnt == i);
      for (int j = 0; j < N; j++)
        if (j != i && m_v[j] && e_gnt != j && m_dst[j] == req_dst[i]) ok = 0;
      for (int k = 0; k < i; k++)
        if (e_acc[k] && req_dst[k] == req_dst[i]) ok = 0;
      e_ready[i] = ok;
      e_acc[i]   = ok && req_valid[i];
    end
    e_mask = 32'd0;
    e_idle = du_stall;
    for (int i = 0; i < N; i++) begin
      if (m_v[i]) e_idle = 1'b0;
      if (m_v[i] && m_dst[i] != 5'd0) e_mask = e_mask | (32'd1 << m_dst[i]);
    end
  endtask

  task automatic model_commit();
    if (rst) begin
      for (int i = 0; i < N; i++) m_v[i] = 0;
      m_ptr = 0;
      sbq.delete();
    end else begin
      if (e_gnt >= 0) begin
        m_v[e_gnt] = 0;
        m_ptr = (e_gnt + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (e_acc[i]) begin
          m_v[i]    = 1;
          m_dst[i]  = req_dst[i];
          m_data[i] = req_data[i];
          if (req_dst[i] != 5'd0) sbq.push_back({req_dst[i], req_data[i]});
        end
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; du_stall = 1'b0;
    settle();
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 3'b111; du_stall = 1'b0;
    req_dst = '0; req_data = '0;
    settle();
    total++; if (req_ready !== 3'b000) $display("FAIL reset_ready: got %b want 000", req_ready); else passed++;
    advance();
    rst = 1'b0; req_valid = '0;
    settle();
    total++; if (rf_we !== 1'b0) $display("FAIL reset_we: got %b want 0", rf_we); else passed++;
    total++; if (rf_dst !== 5'd0 || rf_dstv !== 64'd0) $display("FAIL reset_port: got %0d/%h want 0/0", rf_dst, rf_dstv); else passed++;
    total++; if (pend_mask !== 32'd0) $display("FAIL reset_mask: got %h want 0", pend_mask); else passed++;
    total++; if (du_idle !== 1'b0) $display("FAIL reset_idle_lo: got %b want 0", du_idle); else passed++;
    du_stall = 1'b1; #1;
    total++; if (du_idle !== 1'b1) $display("FAIL reset_idle_hi: got %b want 1", du_idle); else passed++;
    du_stall = 1'b0;
    advance();
  endtask

  task automatic test_single_write();
    do_reset();
    req_valid = 3'b001; req_dst[0] = 5'd5; req_data[0] = 64'hDEAD;
    settle();
    total++; if (req_ready[0] !== 1'b1) $display("FAIL single_ready: got %b want 1", req_ready[0]); else passed++;
    advance();
    req_valid = '0;
    settle();
    total++; if (rf_we !== 1'b1 || rf_dst !== 5'd5 || rf_dstv !== 64'hDEAD)
      $display("FAIL single_write: got we=%b dst=%0d data=%h want 1/5/dead", rf_we, rf_dst, rf_dstv); else passed++;
    total++; if (pend_mask !== 32'h20) $display("FAIL single_mask_set: got %h want 00000020", pend_mask); else passed++;
    advance();
    settle();
    total++; if (pend_mask !== 32'd0 || rf_we !== 1'b0) $display("FAIL single_after: got mask=%h we=%b want 0/0", pend_mask, rf_we); else passed++;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_r;
    do_reset();
    req_valid = 3'b111;
    for (int i = 0; i < N; i++) begin
      req_dst[i] = 5'(i + 1); req_data[i] = 64'h100 + 64'(i);
    end
    settle();
    total++; if (req_ready !== 3'b111) $display("FAIL rr_first_ready: got %b want 111", req_ready); else passed++;
    advance();
    for (int c = 0; c < 6; c++) begin
      settle();
      exp_r = 3'b001 << (c % 3);
      total++; if (rf_we !== 1'b1 || rf_dst !== 5'((c % 3) + 1))
        $display("FAIL rr_grant%0d: got we=%b dst=%0d want 1/%0d", c, rf_we, rf_dst, (c % 3) + 1); else passed++;
      total++; if (req_ready !== exp_r) $display("FAIL rr_ready%0d: got %b want %b", c, req_ready, exp_r); else passed++;
      advance();
    end
    req_valid = '0;
  endtask

  task automatic test_conflict();
    do_reset();
    req_valid = 3'b011; req_dst[0] = 5'd7; req_dst[1] = 5'd7;
    req_data[0] = 64'hAAAA; req_data[1] = 64'hBBBB;
    settle();
    total++; if (req_ready[1:0] !== 2'b01) $display("FAIL conf_same_cycle: got %b want 01", req_ready[1:0]); else passed++;
    advance();
    req_valid = 3'b010;
    settle();
    total++; if (rf_dstv !== 64'hAAAA || req_ready[1] !== 1'b1)
      $display("FAIL conf_first: got data=%h rdy1=%b want aaaa/1", rf_dstv, req_ready[1]); else passed++;
    advance();
    req_valid = '0;
    settle();
    total++; if (rf_we !== 1'b1 || rf_dst !== 5'd7 || rf_dstv !== 64'hBBBB)
      $display("FAIL conf_second: got we=%b dst=%0d data=%h want 1/7/bbbb", rf_we, rf_dst, rf_dstv); else passed++;
    advance();
    do_reset();
    req_valid = 3'b111; req_dst[0] = 5'd3; req_dst[1] = 5'd4; req_dst[2] = 5'd9;
    req_data[2] = 64'h29;
    settle();
    advance();
    req_valid = 3'b001; req_dst[0] = 5'd9; req_data[0] = 64'h99;
    for (int c = 0; c < 3; c++) begin
      settle();
      total++; if (req_ready[0] !== (c == 2)) $display("FAIL conf_buffered%0d: got %b want %b", c, req_ready[0], c == 2); else passed++;
      advance();
    end
    req_valid = '0;
    settle();
    total++; if (rf_dst !== 5'd9 || rf_dstv !== 64'h99) $display("FAIL conf_buf_drain: got %0d/%h want 9/99", rf_dst, rf_dstv); else passed++;
    advance();
  endtask

  task automatic test_x0();
    do_reset();
    req_valid = 3'b011; req_dst[0] = 5'd0; req_data[0] = 64'hFFFF;
    req_dst[1] = 5'd6; req_data[1] = 64'h66;
    settle();
    total++; if (req_ready[1:0] !== 2'b11) $display("FAIL x0_accept: got %b want 11", req_ready[1:0]); else passed++;
    advance();
    req_valid = '0;
    settle();
    total++; if (rf_we !== 1'b0 || rf_dst !== 5'd0) $display("FAIL x0_slot: got we=%b dst=%0d want 0/0", rf_we, rf_dst); else passed++;
    total++; if (pend_mask !== 32'h40) $display("FAIL x0_mask: got %h want 00000040", pend_mask); else passed++;
    advance();
    settle();
    total++; if (rf_we !== 1'b1 || rf_dst !== 5'd6) $display("FAIL x0_next: got we=%b dst=%0d want 1/6", rf_we, rf_dst); else passed++;
    advance();
  endtask

  task automatic test_drain();
    do_reset();
    req_valid = 3'b111;
    for (int i = 0; i < N; i++) begin
      req_dst[i] = 5'(10 + i); req_data[i] = 64'(i);
    end
    settle();
    advance();
    du_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      total++; if (req_ready !== 3'b000 || rf_we !== 1'b1 || du_idle !== 1'b0)
        $display("FAIL drain%0d: got rdy=%b we=%b idle=%b want 000/1/0", c, req_ready, rf_we, du_idle); else passed++;
      advance();
    end
    settle();
    total++; if (du_idle !== 1'b1 || rf_we !== 1'b0) $display("FAIL drain_idle: got idle=%b we=%b want 1/0", du_idle, rf_we); else passed++;
    du_stall = 1'b0; #1;
    model_eval();
    total++; if (req_ready !== 3'b111) $display("FAIL drain_resume: got %b want 111", req_ready); else passed++;
    advance();
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 3'b001; req_dst[0] = 5'd1; req_data[0] = 64'h11;
    settle();
    advance();
    req_valid = 3'b110; req_dst[1] = 5'd2; req_dst[2] = 5'd3;
    settle();
    total++; if (rf_dst !== 5'd1) $display("FAIL rmid_pre: got %0d want 1", rf_dst); else passed++;
    advance();
    req_valid = '0; rst = 1'b1;
    settle();
    total++; if (rf_we !== 1'b0) $display("FAIL rmid_rst_we: got %b want 0", rf_we); else passed++;
    advance();
    rst = 1'b0; req_valid = 3'b011; req_dst[0] = 5'd4; req_dst[1] = 5'd5;
    settle();
    total++; if (rf_we !== 1'b0 || pend_mask !== 32'd0) $display("FAIL rmid_post: got we=%b mask=%h want 0/0", rf_we, pend_mask); else passed++;
    advance();
    req_valid = '0;
    settle();
    total++; if (rf_dst !== 5'd4) $display("FAIL rmid_ptr: got %0d want 4", rf_dst); else passed++;
    advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom % 64) == 0;
      du_stall  = ($urandom % 8) == 0;
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_dst[i]  = 5'($urandom % 8);
        req_data[i] = {$urandom, $urandom};
      end
      settle();
      total++; if (req_ready !== e_ready) $display("FAIL rand_ready@%0d: got %b want %b", c, req_ready, e_ready); else passed++;
      total++; if (rf_we !== e_we || rf_dst !== e_dst || rf_dstv !== e_data)
        $display("FAIL rand_port@%0d: got %b/%0d/%h want %b/%0d/%h", c, rf_we, rf_dst, rf_dstv, e_we, e_dst, e_data); else passed++;
      total++; if (pend_mask !== e_mask) $display("FAIL rand_mask@%0d: got %h want %h", c, pend_mask, e_mask); else passed++;
      total++; if (du_idle !== e_idle) $display("FAIL rand_idle@%0d: got %b want %b", c, du_idle, e_idle); else passed++;
      if (rf_we === 1'b1) begin
        int hit;
        hit = -1;
        for (int q = 0; q < sbq.size(); q++)
          if (hit < 0 && sbq[q][68:64] == rf_dst) hit = q;
        total++;
        if (hit < 0) $display("FAIL rand_order@%0d: write x%0d data %h, want no write", c, rf_dst, rf_dstv);
        else if (sbq[hit][63:0] !== rf_dstv) $display("FAIL rand_order@%0d: got %h want %h", c, rf_dstv, sbq[hit][63:0]);
        else passed++;
        if (hit >= 0) sbq.delete(hit);
      end
      advance();
    end
    rst = 1'b0; req_valid = '0; du_stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_conflict();
    test_x0();
    test_drain();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pu_riscv_rf_wbarb.md
Name: pu_riscv_rf_wbarb

Overview:
- Write-back arbiter that lets NREQ producers share the single register-file write port: ALU/execute write-back, load return and CSR/multi-cycle unit.
- Each requester has a 1-entry holding buffer. Buffered writes are granted round-robin, one per cycle, onto rf_dst/rf_dstv/rf_we.
- Keeps writes to the same register in order and exports a pending-write mask for the issue/hazard logic.
- Supports debug-unit drain: du_stall blocks new requests, and du_idle reports that the buffers are empty.

Parameters:
- XLEN, 64, register data width
- AR_BITS, 5, register address width
- NREQ, 3, number of write requesters (2..8)

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  NREQ  requester i offers a write
- req_dst  in  NREQ x AR_BITS  destination register per requester
- req_data  in  NREQ x XLEN  write data per requester
- req_ready  out  NREQ  requester i write accepted this cycle (valid & ready)
- rf_dst  out  AR_BITS  register-file write address
- rf_dstv  out  XLEN  register-file write data
- rf_we  out  1  register-file write enable
- pend_mask  out  32  bit r set while any buffer holds a write to register r
- du_stall  in  1  debug stall request; blocks new acceptances
- du_idle  out  1  du_stall high and all buffers empty

Behaviour:
- Reset (rst high at a clk edge):
  - all buffers are emptied and the round-robin pointer goes to 0;
  - outputs next cycle: rf_we=0, rf_dst=0, rf_dstv=0, pend_mask=0, req_ready=0 for the reset cycle, du_idle=du_stall.
  - A reset that lands while writes are buffered discards them; no rf_we occurs for those writes.
- Buffer i (valid bit, dst, data):
  - Loads on req_valid[i] & req_ready[i].
  - Clears when granted, unless it is reloaded in the same cycle.
- req_ready[i] = ~rst & ~du_stall & (buf_empty[i] | grant[i]) & ~conflict[i].
- conflict[i] is set when either of these holds:
  - req_dst[i] matches the dst of any valid buffer j≠i that is not granted this cycle;
  - req_dst[i] matches req_dst[k] for some k<i that is also being accepted this cycle. The lower index wins same-cycle ties.
- req_dst == 0:
  - the request is accepted normally;
  - the buffer entry is marked null, still takes a grant slot, drives rf_we=0 on its slot and never sets pend_mask.
- Arbitration:
  - Combinational round-robin over valid buffers. Priority starts at the pointer and wraps NREQ-1→0.
  - On a grant to index g, the pointer becomes (g+1) mod NREQ. With no grant, the pointer holds.
- Write port (combinational from the granted buffer):
  - rf_we = granted & ~null; rf_dst/rf_dstv come from the granted buffer.
  - With no grant: rf_we=0, rf_dst=0, rf_dstv=0.
- Latency:
  - Request accepted at edge N.
  - Earliest rf_we is in the cycle after N; the RF samples it at edge N+1.
  - Worst case: NREQ cycles after acceptance.
- Throughput: one write per cycle sustained. A single requester can stream back-to-back because grant releases ready in the same cycle.
- pend_mask is the OR over valid, non-null buffers of the one-hot dst. It updates at the edge the buffer loads or clears.
- du_stall:
  - new acceptances stop immediately;
  - buffers keep draining;
  - du_idle = du_stall & no valid buffers;
  - dropping du_stall resumes acceptance the same cycle.
- Same-register ordering: at most one buffered write per register at any time, so RF write order per register equals acceptance order.

Decomposition:
- Package pu_riscv_wbarb_pkg holds:
  - localparams WB_ALU=0, WB_LSU=1, WB_MUL=2;
  - a typedef for the buffer entry struct (valid, null, dst, data), parameterised via XLEN/AR_BITS.
- One sub-module: pu_riscv_rr_arbiter. It is a parameterised N-way round-robin arbiter: req vector in, one-hot grant out, pointer register inside, same rst/clk. The top level handles buffers, conflict logic and the mask.

Test Plan:
- Single write: after reset, req_valid=001, dst=5, data=0xDEAD. Required: ready=1 on that cycle; next cycle rf_we=1, rf_dst=5, rf_dstv=0xDEAD; pend_mask bit5 set for exactly that one cycle.
- Round-robin: all three requesters hold valid continuously with dst 1, 2, 3. Required: grant order 0,1,2,0,1,2; one rf_we per cycle; each ready pulses once every 3 cycles.
- Same-dst conflict:
  - Same cycle: req0 and req1 both target dst=7. Required: req0 accepted, req1 ready=0 until buffer0 is granted; RF sees req0's data, then req1's data.
  - Buffered case: a buffered dst=7 write blocks a new dst=7 request from another requester until the buffered write drains.
- x0 write: dst=0, data=0xFFFF. Required: accepted, rf_we stays 0 on its grant slot, pend_mask stays 0.
- Debug drain: three buffers full, then du_stall=1. Required: req_ready=0 throughout; three rf_we cycles; du_idle=1 on the following cycle; du_stall=0 re-enables ready that cycle.
- Reset mid-operation: two buffers valid, then rst=1 for one edge. Required: no rf_we after that edge; pend_mask=0; pointer=0 (next contended grant goes to requester 0).
